instruction_fetch: RTL

// - Fetch stage upstream of decode/register-file read: owns the PC and issues word-addressed reads to instruction memory.
// - Buffers returned instructions, each with its PC, in a small FIFO that the decode stage drains over a valid/ready handshake.
// - Supports PC redirect (branch/jump) with a flush and discard of stale in-flight responses.

---
 rtl/instruction_fetch_pkg.sv | 15 +
 rtl/instruction_fetch_fifo.sv | 61 ++++++
 rtl/instruction_fetch.sv | 96 +++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared widths, defaults and helpers for the fetch stage
package instruction_fetch_pkg;

   localparam int DEF_XLEN       = 32;
   localparam int DEF_RESET_PC   = 0;
   localparam int DEF_FIFO_DEPTH = 2;
   localparam int OPCODE_MSB     = 31;
   localparam int OPCODE_LSB     = 26;

   // bits needed for a counter that must hold every value 0..max_val
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/instruction_fetch_fifo.sv
// rtl/instruction_fetch_fifo.sv - instruction buffer holding {pc, instr} entries for decode
module instruction_fetch_fifo
   import instruction_fetch_pkg::*;
#(
   parameter int WIDTH = 2 * DEF_XLEN,
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic                        push,
   input  logic [WIDTH-1:0]            push_data,
   input  logic                        pop,
   output logic                        empty,
   output logic                        full,
   output logic [cnt_width(DEPTH)-1:0] count,
   output logic [WIDTH-1:0]            head_data
);

   localparam int CW = cnt_width(DEPTH);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty     = (count == '0);
   assign full      = (count == CW'(DEPTH));
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign head_data = mem[rd_ptr];

   // pointers wrap at DEPTH so non-power-of-two depths work too
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // storage, pointers and occupancy; flush discards everything and overrides push/pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         if (do_pop) rd_ptr <= next_ptr(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC ownership, credit-limited imem requests, redirect flush
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int              XLEN       = DEF_XLEN,
   parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEF_RESET_PC),
   parameter int              FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc
);

   localparam int          CW      = cnt_width(FIFO_DEPTH);
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

   logic [XLEN-1:0]   fetch_pc;
   logic [XLEN-1:0]   rsp_pc;
   logic [CW-1:0]     outstanding;
   logic [CW-1:0]     drop_cnt;
   logic [CW-1:0]     fifo_count;
   logic [CW-1:0]     in_flight_next;
   logic [CW:0]       credit_used;
   logic              fifo_empty;
   logic              fifo_full;
   logic              accept;
   logic              push;
   logic              pop;
   logic [2*XLEN-1:0] head;

   // every buffered or in-flight instruction holds one buffer slot, so a push always finds room
   assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding};
   assign imem_req_valid = !rst && (credit_used < DEPTH_W);
   assign imem_req_addr  = fetch_pc;
   assign accept         = imem_req_valid && imem_req_ready;
   assign in_flight_next = outstanding + CW'(accept) - CW'(imem_rsp_valid);
   assign push           = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
   assign pop            = !fifo_empty && if_ready;
   assign if_valid       = !fifo_empty;
   assign if_pc          = head[2*XLEN-1:XLEN];
   assign if_instr       = head[XLEN-1:0];

   instruction_fetch_fifo #(
      .WIDTH (2 * XLEN),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (push),
      .push_data ({rsp_pc, imem_rsp_data}),
      .pop       (pop),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_count),
      .head_data (head)
   );

   // PC, response-PC and in-flight bookkeeping; a redirect overrides every other update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= in_flight_next;
         if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            rsp_pc   <= redirect_pc;
            // everything still in flight after this edge belongs to the old path
            drop_cnt <= in_flight_next;
         end else begin
            if (accept) fetch_pc <= fetch_pc + XLEN'(1);
            if (imem_rsp_valid) begin
               if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
               else                rsp_pc   <= rsp_pc + XLEN'(1);
            end
         end
      end
   end

   // a push into a full buffer means the credit accounting is broken
   a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule
